// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read engine: rd_en issue, 2-entry skid buffer, valid/ready out, sticky underflow.
// Optional FIFO_RD_STATS_EN enables the rd_count delivered-word counter.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  rd_err,
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    typedef enum logic [1:0] {IDLE, RUN, STOP, ERR} state_t;

    state_t                state;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pop;
    logic                  land;
    logic                  uf_land;

    assign m_valid = (occ != 2'd0);
    assign busy    = inflight || m_valid;
    assign pop     = m_valid && m_ready;
    assign land    = inflight && !fifo_underflow;
    assign uf_land = inflight && fifo_underflow;

    // A read is only issued when its word is guaranteed a buffer slot on landing.
    assign fifo_rd_en = (state == RUN) && !fifo_empty && !rst &&
                        ((({1'b0, occ} + {2'b00, inflight}) < 3'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
            occ      <= 2'd0;
            m_data   <= '0;
            slot1    <= '0;
            rd_err   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            // m_data is the buffer head; slot1 is the second entry.
            if (pop && land) begin
                if (occ == 2'd2) begin
                    m_data <= slot1;
                    slot1  <= fifo_data_out;
                end else begin
                    m_data <= fifo_data_out;
                end
            end else if (pop) begin
                m_data <= slot1;
                occ    <= occ - 2'd1;
            end else if (land) begin
                if (occ == 2'd0) begin
                    m_data <= fifo_data_out;
                end else begin
                    slot1 <= fifo_data_out;
                end
                occ <= occ + 2'd1;
            end

            if (uf_land) begin
                rd_err <= 1'b1;
            end else if (err_clr) begin
                rd_err <= 1'b0;
            end

            case (state)
                IDLE: if (en && !rd_err) state <= RUN;
                RUN:  if (!en) state <= STOP;
                STOP: if (!inflight) state <= IDLE;
                ERR:  if (err_clr) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (uf_land) begin
                state <= ERR;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`else
    assign rd_count = '0;
`endif

endmodule
